// File: rtl/fetch_unit.sv
// Purpose : instruction fetch stage; owns the PC, drives instruction memory and fills the IF/ID register.
// Latency : pc_out is the PC register directly (0 cycles); the fetched word lands in IF/ID one cycle later.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall; a bad fetch parks the unit in FAULT until reset.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   pc_out / instr_in             byte address to imem / combinational big-endian instruction word back
//   stall, flush                  hold the stage / turn the IF/ID entry into a bubble
//   redirect, redirect_target     load a new PC (taken branch or jump)
//   if_id_instr/pc/pc_plus4/valid registered fetch result
//   fetch_fault, fault_pc         sticky illegal-fetch flag and the offending PC
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    // Highest legal word address; anything above it lies outside the memory.
    localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic        bad_fetch;
    logic [31:0] pc_plus4;

    assign bad_fetch = (pc_q[1:0] != 2'b00) || (pc_q > PC_MAX);
    // Plain 32-bit add: wraps modulo 2^32 by construction.
    assign pc_plus4  = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        unique case (state_q)
            BOOT: begin
                // One quiet cycle after reset release; nothing is captured.
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // Redirect wins over stall and may rescue a bad PC.
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (stall) begin
                    if (flush) begin
                        valid_d = 1'b0;
                    end
                end else if (bad_fetch) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                    valid_d    = 1'b0;
                end else begin
                    instr_d  = instr_in;
                    id_pc_d  = pc_q;
                    id_pc4_d = pc_plus4;
                    valid_d  = !flush;
                    pc_d     = pc_plus4;
                end
            end
            FAULT: begin
                // Absorbing: only reset leaves this state.
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
                state_d = FAULT;
                fault_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            id_pc_q    <= 32'h0;
            id_pc4_q   <= 32'h0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign pc_out         = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = id_pc_q;
    assign if_id_pc_plus4 = id_pc4_q;
    assign if_id_valid    = valid_q;
    assign fetch_fault    = fault_q;
    assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : directed self-checking bench for fetch_unit with a word-array instruction memory.
// Latency : steps one clock per call, samples 1 time unit after the rising edge.
// Backpressure: stall/flush/redirect driven directly from the stimulus sequence.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [0:127];

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(512)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_out         (pc_out),
        .instr_in       (instr_in),
        .stall          (stall),
        .flush          (flush),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory; out-of-range addresses read as zero.
    assign instr_in = (pc_out < 32'd512) ? imem[pc_out[8:2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},       pc_out,               32'h0);
        chk({tag, "_instr"},    if_id_instr,          32'h0);
        chk({tag, "_idpc"},     if_id_pc,             32'h0);
        chk({tag, "_idpc4"},    if_id_pc_plus4,       32'h0);
        chk({tag, "_valid"},    {31'h0, if_id_valid}, 32'h0);
        chk({tag, "_fault"},    {31'h0, fetch_fault}, 32'h0);
        chk({tag, "_fault_pc"}, fault_pc,             32'h0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'h1000_0000 + 32'(i);
        imem[0]   = 32'h0043_0820;
        imem[1]   = 32'h0043_0822;
        imem[2]   = 32'h0062_0820;
        imem[16]  = 32'hDEAD_BEEF;
        imem[126] = 32'hAAAA_0001;
        imem[127] = 32'hBBBB_0002;

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        #3;
        chk_reset_outputs("rst0");

        // Basic sequential fetch after a BOOT cycle.
        do_reset();
        step();
        chk("boot_valid", {31'h0, if_id_valid}, 32'h0);
        chk("boot_pc",    pc_out,               32'h0);
        step();
        chk("f0_valid", {31'h0, if_id_valid}, 32'h1);
        chk("f0_instr", if_id_instr,          32'h0043_0820);
        chk("f0_pc",    if_id_pc,             32'h0);
        chk("f0_pc4",   if_id_pc_plus4,       32'h4);
        chk("f0_pcout", pc_out,               32'h4);
        step();
        chk("f1_instr", if_id_instr, 32'h0043_0822);
        chk("f1_pc",    if_id_pc,    32'h4);
        step();
        chk("f2_instr", if_id_instr,          32'h0062_0820);
        chk("f2_pc",    if_id_pc,             32'h8);
        chk("f2_valid", {31'h0, if_id_valid}, 32'h1);
        chk("f2_pcout", pc_out,               32'hC);

        // Stall three cycles with PC at 8.
        do_reset();
        step();
        step();
        step();
        chk("pre_stall_pcout", pc_out, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pcout", pc_out,               32'h8);
            chk("stall_pc",    if_id_pc,             32'h4);
            chk("stall_instr", if_id_instr,          32'h0043_0822);
            chk("stall_valid", {31'h0, if_id_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        chk("resume_pc",    if_id_pc,    32'h8);
        chk("resume_instr", if_id_instr, 32'h0062_0820);
        chk("resume_pcout", pc_out,      32'hC);

        // Redirect together with stall.
        redirect = 1'b1;
        redirect_target = 32'h40;
        stall = 1'b1;
        step();
        chk("redir_pcout", pc_out,               32'h40);
        chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
        chk("redir_hold",  if_id_pc,             32'h8);
        redirect = 1'b0;
        stall = 1'b0;
        step();
        chk("redir_tgt_pc",    if_id_pc,             32'h40);
        chk("redir_tgt_valid", {31'h0, if_id_valid}, 32'h1);
        chk("redir_tgt_instr", if_id_instr,          32'hDEAD_BEEF);
        chk("redir_tgt_pc4",   if_id_pc_plus4,       32'h44);

        // Flush during a normal fetch at PC 4, then flush under stall.
        do_reset();
        step();
        step();
        flush = 1'b1;
        step();
        chk("flush_valid", {31'h0, if_id_valid}, 32'h0);
        chk("flush_pcout", pc_out,               32'h8);
        chk("flush_pc",    if_id_pc,             32'h4);
        flush = 1'b0;
        step();
        chk("post_flush_valid", {31'h0, if_id_valid}, 32'h1);
        chk("post_flush_pc",    if_id_pc,             32'h8);
        stall = 1'b1;
        flush = 1'b1;
        step();
        chk("sflush_valid", {31'h0, if_id_valid}, 32'h0);
        chk("sflush_pcout", pc_out,               32'hC);
        chk("sflush_pc",    if_id_pc,             32'h8);
        stall = 1'b0;
        flush = 1'b0;

        // Redirect to a misaligned target faults one cycle later.
        redirect = 1'b1;
        redirect_target = 32'h1FE;
        step();
        chk("mis_pcout",    pc_out,               32'h1FE);
        chk("mis_fault0",   {31'h0, fetch_fault}, 32'h0);
        redirect = 1'b0;
        step();
        chk("mis_fault",    {31'h0, fetch_fault}, 32'h1);
        chk("mis_fault_pc", fault_pc,             32'h1FE);
        chk("mis_valid",    {31'h0, if_id_valid}, 32'h0);
        redirect = 1'b1;
        redirect_target = 32'h40;
        flush = 1'b1;
        step();
        chk("fault_redir_ign", pc_out,               32'h1FE);
        chk("fault_sticky",    {31'h0, fetch_fault}, 32'h1);
        chk("fault_idpc_hold", if_id_pc,             32'h8);
        redirect = 1'b0;
        flush = 1'b0;

        // Asynchronous reset while in FAULT, observed before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_boot_valid", {31'h0, if_id_valid}, 32'h0);
        step();
        chk("arst_f0_instr", if_id_instr,          32'h0043_0820);
        chk("arst_f0_valid", {31'h0, if_id_valid}, 32'h1);

        // Sequential run off the end of memory.
        do_reset();
        step();
        redirect = 1'b1;
        redirect_target = 32'h1F8;
        step();
        redirect = 1'b0;
        step();
        chk("end0_pc",    if_id_pc,    32'h1F8);
        chk("end0_instr", if_id_instr, 32'hAAAA_0001);
        step();
        chk("end1_pc",    if_id_pc,    32'h1FC);
        chk("end1_instr", if_id_instr, 32'hBBBB_0002);
        chk("end1_pc4",   if_id_pc_plus4, 32'h200);
        chk("end1_pcout", pc_out,      32'h200);
        step();
        chk("end_fault",    {31'h0, fetch_fault}, 32'h1);
        chk("end_fault_pc", fault_pc,             32'h200);
        chk("end_valid",    {31'h0, if_id_valid}, 32'h0);
        chk("end_pcout",    pc_out,               32'h200);
        chk("end_idpc",     if_id_pc,             32'h1FC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_BYTES, default 512: byte size of the instruction memory; legal fetch addresses are 0..IMEM_BYTES-4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_out  output  32  byte address presented to instruction memory.
REQ-006 instr_in  input  32  instruction word returned combinationally by instruction memory for pc_out, big-endian byte order.
REQ-007 stall  input  1  hold PC and IF/ID contents.
REQ-008 flush  input  1  kill the IF/ID entry (insert bubble).
REQ-009 redirect  input  1  load redirect_target into PC (taken branch/jump).
REQ-010 redirect_target  input  32  new PC on redirect.
REQ-011 if_id_instr  output  32  registered fetched instruction.
REQ-012 if_id_pc  output  32  registered PC of if_id_instr.
REQ-013 if_id_pc_plus4  output  32  registered if_id_pc + 4.
REQ-014 if_id_valid  output  1  IF/ID entry holds a real instruction.
REQ-015 fetch_fault  output  1  sticky illegal-fetch flag.
REQ-016 fault_pc  output  32  PC that caused the fault.

Function
REQ-017 pc_out SHALL equal the PC register combinationally; no added latency to instruction memory.
REQ-018 States SHALL be BOOT, RUN, FAULT; BOOT lasts exactly one cycle after rst_n deasserts, performs no IF/ID capture, then goes to RUN.
REQ-019 A fetch is "bad" when PC[1:0] != 0 or PC > IMEM_BYTES-4.
REQ-020 In RUN, per-cycle priority SHALL be redirect > stall > normal; flush applies independently to IF/ID as below.
REQ-021 Redirect: PC <= redirect_target; if_id_valid <= 0; IF/ID data fields hold; stall ignored; legal even if current PC is bad.
REQ-022 Stall (no redirect): PC and all IF/ID fields hold, except flush=1 forces if_id_valid <= 0.
REQ-023 Normal (no redirect, no stall, fetch not bad): if_id_instr <= instr_in, if_id_pc <= PC, if_id_pc_plus4 <= PC+4, if_id_valid <= !flush, PC <= PC+4.
REQ-024 Normal with bad fetch: state <= FAULT, fault_pc <= PC, fetch_fault <= 1, if_id_valid <= 0, PC holds.
REQ-025 FAULT SHALL be absorbing until reset: PC, IF/ID fields hold, if_id_valid 0, fetch_fault 1; redirect, stall, flush ignored.
REQ-026 All PC additions SHALL be 32-bit modulo 2^32 (PC+4 from 32'hFFFF_FFFC gives 0).
REQ-027 Fetch-to-IF/ID latency SHALL be one cycle: instruction at PC N visible on if_id_* the cycle after PC=N is presented.

Reset
REQ-028 rst_n low SHALL immediately (without clock) set PC=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, fetch_fault=0, fault_pc=0, state=BOOT.
REQ-029 Reset asserted mid-operation, including in FAULT, SHALL abandon all state and apply REQ-028; outputs hold reset values while rst_n is low.

Verification
REQ-030 Reset release, memory loaded 0x00430820/0x00430822/0x00620820 at 0/4/8, no stall -> BOOT cycle, then if_id_valid=1 with (instr,pc)=(0x00430820,0),(0x00430822,4),(0x00620820,8) on consecutive cycles.
REQ-031 stall=1 for 3 cycles at PC=8 -> pc_out stays 8, if_id_* unchanged, fetch resumes at 8 with no lost or duplicated instruction.
REQ-032 redirect=1 target 0x40 together with stall=1 -> next cycle pc_out=0x40, if_id_valid=0; following cycle if_id_pc=0x40, valid=1.
REQ-033 flush=1 during normal fetch at PC=4 -> if_id_valid=0 next cycle, pc_out=8.
REQ-034 redirect target 0x1FE (misaligned) -> one cycle later fetch_fault=1, fault_pc=0x1FE, if_id_valid=0; sequential run from 0x1F8 -> fault at 0x200; later redirect ignored.
REQ-035 rst_n pulsed low asynchronously while in FAULT -> all outputs reset values before next clock edge; normal fetch from RESET_PC after BOOT.
